// File: rtl/alt_eyemon_sweep_ctrl.sv
// Eye-monitor phase sweep sequencer: steps a linear phase range, programs the
// non-linear hardware phase code, settles, counts bit errors and reports per step.

module alt_eyemon_rom (
    input  logic [5:0] step,
    output logic [5:0] code
);
    // Four 16-entry segments: reversed-high, identity, reversed-low, shifted-down.
    always_comb begin
        code = step;
        case (step[5:4])
            2'd0:    code = 6'd63 - {2'b00, step[3:0]};
            2'd1:    code = step;
            2'd2:    code = 6'd15 - {2'b00, step[3:0]};
            default: code = {2'b10, step[3:0]};
        endcase
    end
endmodule

module alt_eyemon_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 8,
    parameter int DWELL_W       = 16,
    parameter int ERR_W         = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [5:0]         i_step_first,
    input  logic [5:0]         i_step_last,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_bit_err,
    output logic               o_ph_wr,
    output logic [5:0]         o_ph_code,
    input  logic               i_ph_ack,
    output logic               o_res_valid,
    output logic [5:0]         o_res_step,
    output logic [ERR_W-1:0]   o_res_errcnt,
    input  logic               i_res_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_aborted,
    output logic               o_cfg_err,
    output logic [2:0]         o_dbg_state
);
    // Handshakes: o_ph_wr/o_res_valid are levels held with stable payload until the
    // cycle the partner's ack/ready is sampled high; i_abort overrides both.
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = (DWELL_W > SW) ? DWELL_W : SW;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_DWELL, S_REPORT, S_DONE
    } state_t;

    state_t             state, state_d;
    logic [5:0]         step_q, step_d, last_q, last_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               cfg_bad, abort_evt;
    logic [5:0]         rom_code;

    alt_eyemon_rom u_rom (
        .step (step_d),
        .code (rom_code)
    );

    assign o_dbg_state = state;

    always_comb begin
        state_d   = state;
        step_d    = step_q;
        last_d    = last_q;
        dwell_d   = dwell_q;
        tmr_d     = tmr_q;
        err_d     = err_q;
        cfg_bad   = 1'b0;
        abort_evt = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_step_first > i_step_last) begin
                        cfg_bad = 1'b1;
                    end else begin
                        step_d  = i_step_first;
                        last_d  = i_step_last;
                        dwell_d = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (i_ph_ack) begin
                    tmr_d   = TW'(SETTLE_CYCLES - 1);
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (tmr_q == '0) begin
                    tmr_d   = TW'(dwell_q - DWELL_W'(1));
                    err_d   = '0;
                    state_d = S_DWELL;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_DWELL: begin
                if (i_bit_err && (err_q != '1)) err_d = err_q + ERR_W'(1);
                if (tmr_q == '0) state_d = S_REPORT;
                else tmr_d = tmr_q - TW'(1);
            end
            S_REPORT: begin
                if (i_res_ready) begin
                    if (step_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        step_d  = step_q + 6'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state != S_IDLE && i_abort) begin
            abort_evt = 1'b1;
            state_d   = S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            step_q       <= '0;
            last_q       <= '0;
            dwell_q      <= '0;
            tmr_q        <= '0;
            err_q        <= '0;
            o_ph_wr      <= 1'b0;
            o_ph_code    <= 6'h3F;
            o_res_valid  <= 1'b0;
            o_res_step   <= '0;
            o_res_errcnt <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_aborted    <= 1'b0;
            o_cfg_err    <= 1'b0;
        end else begin
            state       <= state_d;
            step_q      <= step_d;
            last_q      <= last_d;
            dwell_q     <= dwell_d;
            tmr_q       <= tmr_d;
            err_q       <= err_d;
            o_ph_wr     <= (state_d == S_LOAD);
            o_res_valid <= (state_d == S_REPORT);
            o_busy      <= (state_d != S_IDLE);
            o_done      <= (state_d == S_DONE);
            o_aborted   <= abort_evt;
            o_cfg_err   <= cfg_bad;
            if (state_d == S_LOAD) o_ph_code <= rom_code;
            // Result payload captured once, including the final dwell cycle's error.
            if (state == S_DWELL && state_d == S_REPORT) begin
                o_res_step   <= step_q;
                o_res_errcnt <= err_d;
            end
        end
    end
endmodule

// File: doc/alt_eyemon_sweep_ctrl.md
# alt_eyemon_sweep_ctrl

Sequencer for the transceiver eye monitor: sweeps a user-specified range of linear phase steps (0-63), maps each step to its non-linear hardware phase code, writes that code to the eye-monitor phase register with a request/acknowledge handshake, waits a settle time, and counts bit errors over a programmable dwell window. Each step's error count is delivered to the host-side collector over a valid/ready result interface. The block instantiates `alt_eyemon_rom` internally for the step-to-code mapping.

## Interface
- `SETTLE_CYCLES`, 8, cycles waited after phase ack before counting (>=1)
- `DWELL_W`, 16, width of dwell length
- `ERR_W`, 16, width of per-step error count
- `i_clk` in 1: single clock
- `i_rst_n` in 1: reset, synchronous, active-low
- `i_start` in 1: start sweep; sampled only in IDLE
- `i_abort` in 1: terminate sweep
- `i_step_first` in 6: first linear step
- `i_step_last` in 6: last linear step
- `i_dwell` in DWELL_W: dwell cycles per step (0 treated as 1)
- `i_bit_err` in 1: one error per cycle when high
- `o_ph_wr` in/out out 1: phase write request (level)
- `o_ph_code` out 6: hardware phase code (ROM output for current step)
- `i_ph_ack` in 1: phase write accepted
- `o_res_valid` out 1: result available
- `o_res_step` out 6: linear step of result
- `o_res_errcnt` out ERR_W: saturating error count
- `i_res_ready` in 1: collector accepts result
- `o_busy` out 1: high in any state except IDLE
- `o_done` out 1: 1-cycle pulse, sweep completed
- `o_aborted` out 1: 1-cycle pulse, sweep aborted
- `o_cfg_err` out 1: 1-cycle pulse, start rejected (first > last)

## Operation
- States: IDLE, LOAD, SETTLE, DWELL, REPORT, DONE.
- IDLE: on `i_start`, latch first/last/dwell (0 -> 1); if first > last, pulse `o_cfg_err` next cycle and stay IDLE; else step <= first, go LOAD.
- LOAD: `o_ph_wr`=1, `o_ph_code`=ROM(step), held stable until the cycle `i_ph_ack`=1 (ack in first LOAD cycle valid); then SETTLE. No timeout.
- SETTLE: exactly SETTLE_CYCLES cycles, errors ignored; then DWELL with error counter cleared.
- DWELL: exactly dwell cycles; each cycle with `i_bit_err`=1 increments the counter; saturates at all-ones. Then REPORT.
- REPORT: `o_res_valid`=1, `o_res_step`=step, `o_res_errcnt` stable until the cycle `i_res_ready`=1. Then if step == last -> DONE, else step+1 -> LOAD.
- DONE: pulse `o_done` one cycle, return IDLE.
- `i_abort` in any non-IDLE state: next cycle IDLE, `o_aborted` pulse, all handshake outputs drop; pending result discarded. Abort has priority over ack/ready in the same cycle. `i_abort` in IDLE ignored.
- `i_start` while busy ignored; inputs latched only at start, later changes have no effect.
- first == last: single-step sweep. last = 63: no wrap, terminates after step 63.
- Mapping (via ROM): 0-15 -> 63 down to 48; 16-31 -> 16-31; 32-47 -> 15 down to 0; 48-63 -> 32-47.

## Timing
- Reset (i_rst_n=0 at clock edge): state IDLE; `o_ph_wr`, `o_res_valid`, `o_busy`, `o_done`, `o_aborted`, `o_cfg_err` = 0; `o_ph_code` = 6'h3F; `o_res_step` = 0; `o_res_errcnt` = 0. Reset mid-sweep behaves identically, no pulses.
- All outputs registered. `o_ph_wr` rises the cycle after `i_start` is sampled.
- Per step with immediate ack/ready: 1 (LOAD) + SETTLE_CYCLES + dwell + 1 (REPORT) cycles.
- `o_done` asserted the cycle after the final REPORT handshake; `o_busy` low the cycle after that.
- Error counted only if `i_bit_err` high in a DWELL cycle; the cycle after the last DWELL cycle is not counted.

## Test plan
- Reset, then start first=0,last=0,dwell=10, ack/ready tied high, `i_bit_err`=1 always -> one LOAD with code 6'h3F, result step=0 errcnt=10, `o_done` after 1+8+10+1 cycles.
- Sweep first=14,last=17, dwell=4, no errors -> codes 6'h31,6'h30,6'h10,6'h11 in order; four results with errcnt=0, one `o_done`.
- first=20,last=5 -> `o_cfg_err` pulse, no `o_ph_wr`, `o_busy` stays 0.
- ERR_W=4, dwell=100, `i_bit_err`=1 -> errcnt saturates at 15; dwell=0 -> exactly 1 cycle counted.
- Ack delayed 5 cycles and ready delayed 3 cycles -> `o_ph_code`/result fields stable throughout; errors during LOAD/SETTLE/REPORT not counted.
- Abort asserted in DWELL of step 33 (same cycle as `i_bit_err`) -> `o_aborted` pulse, no result, no `o_done`; new start then runs normally from first step.
